// File: rtl/kernel_launcher.sv
// kernel_launcher: host-side launch sequencer sitting in front of the gpu top.
// Takes one launch request, resets the gpu, writes the thread count to the
// device control register, runs the kernel until done or timeout, and hands a
// status/cycle-count result back to the host.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a launch request, host_launch_ready high
// RST     | gpu_reset held for RESET_CYCLES cycles before programming
// DCR     | single-cycle device control register write (thread count)
// RUN     | start held high, cycle counter running, watching done/timeout
// RECOVER | timeout hit: gpu_reset held for RESET_CYCLES cycles
// RESULT  | result_valid high until the host takes it with result_ready
module kernel_launcher #(
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT_BITS = 16,
  parameter int CYCLE_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_launch_valid,
  output logic                    host_launch_ready,
  input  logic [7:0]              host_thread_count,
  input  logic [TIMEOUT_BITS-1:0] host_timeout,
  output logic                    gpu_reset,
  output logic                    device_control_write_enable,
  output logic [7:0]              device_control_data,
  output logic                    start,
  input  logic                    done,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [1:0]              result_status,
  output logic [CYCLE_BITS-1:0]   result_cycles,
  output logic                    busy
);

  // Timeout compare is done at the wider of the two widths so a narrow cycle
  // counter never aliases against a larger timeout value.
  localparam int CMP_W = (TIMEOUT_BITS > CYCLE_BITS) ? TIMEOUT_BITS : CYCLE_BITS;
  localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_EMPTY   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_DCR,
    S_RUN,
    S_RECOVER,
    S_RESULT
  } state_t;

  state_t                  state_q, state_d;
  logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;
  logic [7:0]              thread_q, thread_d;
  logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d;
  logic [CYCLE_BITS-1:0]   cyc_q, cyc_d;
  logic [1:0]              status_q, status_d;
  logic [CYCLE_BITS-1:0]   res_cycles_q, res_cycles_d;

  logic timeout_hit;
  logic cyc_sat;

  assign cyc_sat     = (cyc_q == {CYCLE_BITS{1'b1}});
  assign timeout_hit = (timeout_q != '0) && (CMP_W'(cyc_q) == CMP_W'(timeout_q));

  // State and datapath registers; reset returns everything to IDLE with zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      thread_q     <= '0;
      timeout_q    <= '0;
      cyc_q        <= '0;
      status_q     <= '0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      thread_q     <= thread_d;
      timeout_q    <= timeout_d;
      cyc_q        <= cyc_d;
      status_q     <= status_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  // Next-state logic and datapath updates for the launch sequence.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    thread_d     = thread_q;
    timeout_d    = timeout_q;
    cyc_d        = cyc_q;
    status_d     = status_q;
    res_cycles_d = res_cycles_q;

    case (state_q)
      S_IDLE: begin
        if (host_launch_valid) begin
          thread_d  = host_thread_count;
          timeout_d = host_timeout;
          if (host_thread_count == 8'd0) begin
            state_d      = S_RESULT;
            status_d     = ST_EMPTY;
            res_cycles_d = '0;
          end else begin
            state_d   = S_RST;
            rst_cnt_d = RC_LOAD;
          end
        end
      end
      S_RST: begin
        if (rst_cnt_q == '0) state_d = S_DCR;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      S_DCR: begin
        state_d = S_RUN;
        cyc_d   = CYCLE_BITS'(1);
      end
      S_RUN: begin
        // done takes priority over a coincident timeout
        if (done) begin
          state_d      = S_RESULT;
          status_d     = ST_OK;
          res_cycles_d = cyc_q;
        end else if (timeout_hit) begin
          state_d      = S_RECOVER;
          status_d     = ST_TIMEOUT;
          res_cycles_d = cyc_q;
          rst_cnt_d    = RC_LOAD;
        end else if (!cyc_sat) begin
          cyc_d = cyc_q + CYCLE_BITS'(1);
        end
      end
      S_RECOVER: begin
        if (rst_cnt_q == '0) state_d = S_RESULT;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      S_RESULT: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; reset gates the strobes so they fall without waiting a clock.
  always_comb begin
    host_launch_ready           = (state_q == S_IDLE) && !reset;
    gpu_reset                   = reset || (state_q == S_RST) || (state_q == S_RECOVER);
    device_control_write_enable = (state_q == S_DCR) && !reset;
    device_control_data         = device_control_write_enable ? thread_q : 8'd0;
    start                       = (state_q == S_RUN) && !reset;
    result_valid                = (state_q == S_RESULT) && !reset;
    result_status               = status_q;
    result_cycles               = res_cycles_q;
    busy                        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_kernel_launcher.sv
// Directed bench for kernel_launcher: a vector table of complete launches plus
// hand sequences for result back-pressure, mid-run reset and counter saturation.
module tb_kernel_launcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_launch_valid;
  logic        host_launch_ready;
  logic [7:0]  host_thread_count;
  logic [15:0] host_timeout;
  logic        gpu_reset;
  logic        device_control_write_enable;
  logic [7:0]  device_control_data;
  logic        start;
  logic        done;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_status;
  logic [15:0] result_cycles;
  logic        busy;

  logic        v4, rdy4, grst4, we4, start4, done4, rv4, rr4, busy4;
  logic [7:0]  thr4, dcd4;
  logic [15:0] to4;
  logic [1:0]  st4;
  logic [3:0]  cyc4;

  always #5 clk = ~clk;

  kernel_launcher dut (
    .clk(clk), .reset(reset),
    .host_launch_valid(host_launch_valid), .host_launch_ready(host_launch_ready),
    .host_thread_count(host_thread_count), .host_timeout(host_timeout),
    .gpu_reset(gpu_reset),
    .device_control_write_enable(device_control_write_enable),
    .device_control_data(device_control_data),
    .start(start), .done(done),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_status(result_status), .result_cycles(result_cycles),
    .busy(busy)
  );

  kernel_launcher #(.CYCLE_BITS(4)) dut4 (
    .clk(clk), .reset(reset),
    .host_launch_valid(v4), .host_launch_ready(rdy4),
    .host_thread_count(thr4), .host_timeout(to4),
    .gpu_reset(grst4),
    .device_control_write_enable(we4),
    .device_control_data(dcd4),
    .start(start4), .done(done4),
    .result_valid(rv4), .result_ready(rr4),
    .result_status(st4), .result_cycles(cyc4),
    .busy(busy4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  thr;
    logic [15:0] to;
    int          done_at;
    logic [1:0]  exp_status;
    int          exp_cycles;
    int          exp_rst;
  } vec_t;

  vec_t vecs[6];

  int         mon_rst, mon_we, mon_run, mon_bad;
  logic [7:0] mon_data;

  // Wait (bounded) for ready, then present one request for one clock.
  task automatic do_accept(input logic [7:0] thr, input logic [15:0] to);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (host_launch_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("accept_ready_bound", 32'(ok), 1);
    host_launch_valid = 1'b1;
    host_thread_count = thr;
    host_timeout      = to;
    @(negedge clk);
    host_launch_valid = 1'b0;
  endtask

  // Observe one launch until result_valid, driving done on RUN cycle done_at.
  task automatic monitor(input int done_at);
    bit got = 0;
    mon_rst = 0; mon_we = 0; mon_run = 0; mon_bad = 0; mon_data = 8'hxx;
    for (int i = 0; i < 400; i++) begin
      if (result_valid) begin got = 1; break; end
      if (gpu_reset) mon_rst++;
      if (device_control_write_enable) begin
        mon_we++;
        mon_data = device_control_data;
      end else if (device_control_data != 8'd0) mon_bad++;
      if (start && (gpu_reset || device_control_write_enable)) mon_bad++;
      if (start) begin
        mon_run++;
        done = (mon_run == done_at);
      end else begin
        done = 1'b0;
      end
      @(negedge clk);
    end
    done = 1'b0;
    chk("result_wait_bound", 32'(got), 1);
    chk("overlap_or_stray_dcr", 32'(mon_bad), 0);
  endtask

  task automatic release_result(input logic [1:0] exp_status, input int exp_cycles);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("post_ready_valid", 32'(result_valid), 0);
    chk("post_ready_launch_ready", 32'(host_launch_ready), 1);
    chk("post_ready_busy", 32'(busy), 0);
    chk("idle_status_held", 32'(result_status), 32'(exp_status));
    chk("idle_cycles_held", 32'(result_cycles), 32'(exp_cycles));
  endtask

  initial begin
    //          thr    to     done  status cycles rst
    vecs[0] = '{8'd8,   16'd0,  5, 2'd0,  5,  2};
    vecs[1] = '{8'd0,   16'd0,  0, 2'd2,  0,  0};
    vecs[2] = '{8'd4,   16'd10, 0, 2'd1,  10, 4};
    vecs[3] = '{8'd3,   16'd3,  3, 2'd0,  3,  2};
    vecs[4] = '{8'd255, 16'd1,  0, 2'd1,  1,  4};
    vecs[5] = '{8'd1,   16'd0,  1, 2'd0,  1,  2};

    reset = 1'b1;
    host_launch_valid = 0; host_thread_count = 0; host_timeout = 0;
    done = 0; result_ready = 0;
    v4 = 0; thr4 = 0; to4 = 0; done4 = 0; rr4 = 0;

    #1;
    chk("rst_launch_ready", 32'(host_launch_ready), 0);
    chk("rst_gpu_reset", 32'(gpu_reset), 1);
    chk("rst_start", 32'(start), 0);
    chk("rst_dcr_we", 32'(device_control_write_enable), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_status", 32'(result_status), 0);
    chk("rst_cycles", 32'(result_cycles), 0);
    chk("rst_busy", 32'(busy), 0);

    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_launch_ready", 32'(host_launch_ready), 1);
    chk("idle_gpu_reset", 32'(gpu_reset), 0);

    for (int k = 0; k < 6; k++) begin
      do_accept(vecs[k].thr, vecs[k].to);
      monitor(vecs[k].done_at);
      chk($sformatf("v%0d_rst_cycles", k), 32'(mon_rst), 32'(vecs[k].exp_rst));
      chk($sformatf("v%0d_dcr_writes", k), 32'(mon_we), (vecs[k].thr != 0) ? 32'd1 : 32'd0);
      if (vecs[k].thr != 0)
        chk($sformatf("v%0d_dcr_data", k), 32'(mon_data), 32'(vecs[k].thr));
      chk($sformatf("v%0d_run_cycles", k), 32'(mon_run), 32'(vecs[k].exp_cycles));
      chk($sformatf("v%0d_status", k), 32'(result_status), 32'(vecs[k].exp_status));
      chk($sformatf("v%0d_cycles", k), 32'(result_cycles), 32'(vecs[k].exp_cycles));
      chk($sformatf("v%0d_busy", k), 32'(busy), 1);
      chk($sformatf("v%0d_ready_low", k), 32'(host_launch_ready), 0);
      release_result(vecs[k].exp_status, vecs[k].exp_cycles);
    end

    // Back-pressure on the result with a new request already waiting.
    do_accept(8'd2, 16'd0);
    monitor(2);
    host_launch_valid = 1'b1;
    host_thread_count = 8'd5;
    host_timeout      = 16'd0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(result_valid), 1);
      chk("stall_launch_ready", 32'(host_launch_ready), 0);
      chk("stall_status", 32'(result_status), 0);
      chk("stall_cycles", 32'(result_cycles), 2);
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("stall_release_ready", 32'(host_launch_ready), 1);
    chk("stall_release_valid", 32'(result_valid), 0);
    @(negedge clk);
    host_launch_valid = 1'b0;
    chk("next_accept_busy", 32'(busy), 1);
    chk("next_accept_gpu_reset", 32'(gpu_reset), 1);
    monitor(1);
    chk("next_dcr_data", 32'(mon_data), 5);
    chk("next_status", 32'(result_status), 0);
    chk("next_cycles", 32'(result_cycles), 1);
    release_result(2'd0, 1);

    // Reset asserted on the 4th RUN cycle.
    do_accept(8'd6, 16'd0);
    begin
      int run = 0;
      bit hit = 0;
      for (int i = 0; i < 50; i++) begin
        if (start) run++;
        if (run == 4) begin hit = 1; break; end
        @(negedge clk);
      end
      chk("midrun_reach_bound", 32'(hit), 1);
    end
    reset = 1'b1;
    #1;
    chk("midrun_start", 32'(start), 0);
    chk("midrun_gpu_reset", 32'(gpu_reset), 1);
    chk("midrun_dcr_we", 32'(device_control_write_enable), 0);
    chk("midrun_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_launch_ready", 32'(host_launch_ready), 1);
    chk("after_rst_result_valid", 32'(result_valid), 0);
    chk("after_rst_gpu_reset", 32'(gpu_reset), 0);
    chk("after_rst_cycles", 32'(result_cycles), 0);

    // 4-bit cycle counter saturates at 15.
    begin
      int run = 0;
      bit got = 0;
      chk("sat_ready", 32'(rdy4), 1);
      v4 = 1'b1; thr4 = 8'd3; to4 = 16'd0;
      @(negedge clk);
      v4 = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (rv4) begin got = 1; break; end
        if (start4) begin
          run++;
          done4 = (run == 20);
        end else done4 = 1'b0;
        @(negedge clk);
      end
      done4 = 1'b0;
      chk("sat_result_bound", 32'(got), 1);
      chk("sat_run_cycles", 32'(run), 20);
      chk("sat_status", 32'(st4), 0);
      chk("sat_cycles", 32'(cyc4), 15);
      rr4 = 1'b1;
      @(negedge clk);
      rr4 = 1'b0;
      chk("sat_release_valid", 32'(rv4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
